// File: rtl/sd_dat_pkg.sv
// Shared types and sizing for the SD DAT transfer scheduler.
// Holds the scheduler state enum and default field widths.
package sd_dat_pkg;

  localparam int SD_MAX_BLKSZ = 2048;
  localparam int SD_BLKSZ_W   = $clog2(SD_MAX_BLKSZ) + 1;
  localparam int SD_BLKCNT_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FIFO_WAIT,
    ST_LAUNCH,
    ST_PHY_WAIT,
    ST_NEXT,
    ST_STOP_REQ,
    ST_FINISH
  } dat_state_e;

endpackage

// File: rtl/dat_xfer_sched_if.sv
// Scheduler <-> DAT phy / command path handshake bundle.
// master: scheduler side; slave: phy and CMD12 issuer side.
interface dat_xfer_sched_if #(
  parameter int BLKSZ_W = 12
);

  logic               phy_start;
  logic [BLKSZ_W-1:0] phy_len;
  logic               phy_dir;
  logic               phy_done;
  logic               phy_crc_err;
  logic               cmd12_req;
  logic               cmd12_ack;

  modport master (
    output phy_start,
    output phy_len,
    output phy_dir,
    input  phy_done,
    input  phy_crc_err,
    output cmd12_req,
    input  cmd12_ack
  );

  modport slave (
    input  phy_start,
    input  phy_len,
    input  phy_dir,
    output phy_done,
    output phy_crc_err,
    input  cmd12_req,
    output cmd12_ack
  );

endinterface

// File: rtl/dat_blk_counter.sv
// Loadable block down-counter with zero flag.
// Ports: clk, reset, load/load_val, dec -> count, zero.
module dat_blk_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  assign zero = (count == '0);

  // Decrement saturates at zero so the count never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !zero) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/dat_xfer_sched.sv
// SD DAT block-transfer sequencer: FIFO gate, phy launch, CMD12.
// Ports: clk/reset/sw_reset_dat, start+mode, abort, fifo_ack, dat bundle, status.
module dat_xfer_sched
  import sd_dat_pkg::*;
#(
  parameter int BLKSZ_W  = SD_BLKSZ_W,
  parameter int BLKCNT_W = SD_BLKCNT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sw_reset_dat,
  input  logic                start,
  input  logic                multi_block,
  input  logic                dir_read,
  input  logic                blk_cnt_en,
  input  logic                auto_cmd12_en,
  input  logic [BLKSZ_W-1:0]  block_size,
  input  logic [BLKCNT_W-1:0] block_count,
  input  logic                abort,
  input  logic                fifo_ack,
  dat_xfer_sched_if.master    dat,
  output logic                busy,
  output logic                xfer_done,
  output logic                xfer_err,
  output logic [BLKCNT_W-1:0] blocks_left
);

  dat_state_e state;
  dat_state_e state_nx;

  logic clr;
  logic start_ok;
  logic bounded_in;
  logic err_q;
  logic abort_q;
  logic multi_q;
  logic auto_q;
  logic bounded_q;
  logic dir_q;
  logic [BLKSZ_W-1:0] len_q;

  logic                cnt_dec;
  logic                cnt_zero;
  logic [BLKCNT_W-1:0] cnt_init;
  logic                stop_cmd12;
  logic                last_blk;

  assign clr        = reset | sw_reset_dat;
  assign start_ok   = start & (state == ST_IDLE);
  assign bounded_in = ~multi_block | blk_cnt_en;
  assign stop_cmd12 = multi_q & auto_q;

  // Unbounded transfers never look at the count, so it loads zero.
  assign cnt_init = !multi_block ? BLKCNT_W'(1)
                  : blk_cnt_en   ? block_count
                  : '0;

  // An abort seen in the NEXT cycle itself still ends the transfer.
  assign last_blk = (bounded_q & cnt_zero) | abort_q | abort;

  dat_blk_counter #(
    .W (BLKCNT_W)
  ) u_cnt (
    .clk      (clk),
    .reset    (clr),
    .load     (start_ok),
    .load_val (cnt_init),
    .dec      (cnt_dec),
    .count    (blocks_left),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_dec  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          if (block_size == '0) begin
            state_nx = ST_FINISH;
          end else if (bounded_in && cnt_init == '0) begin
            state_nx = ST_FINISH;
          end else begin
            state_nx = ST_FIFO_WAIT;
          end
        end
      end
      ST_FIFO_WAIT: begin
        if (fifo_ack) begin
          state_nx = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        state_nx = ST_PHY_WAIT;
      end
      ST_PHY_WAIT: begin
        if (dat.phy_done) begin
          if (dat.phy_crc_err) begin
            state_nx = stop_cmd12 ? ST_STOP_REQ : ST_FINISH;
          end else begin
            state_nx = ST_NEXT;
            cnt_dec  = bounded_q;
          end
        end
      end
      ST_NEXT: begin
        if (last_blk) begin
          state_nx = stop_cmd12 ? ST_STOP_REQ : ST_FINISH;
        end else begin
          state_nx = ST_FIFO_WAIT;
        end
      end
      ST_STOP_REQ: begin
        if (dat.cmd12_ack) begin
          state_nx = ST_FINISH;
        end
      end
      ST_FINISH: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      err_q     <= 1'b0;
      abort_q   <= 1'b0;
      multi_q   <= 1'b0;
      auto_q    <= 1'b0;
      bounded_q <= 1'b0;
      dir_q     <= 1'b0;
      len_q     <= '0;
    end else if (start_ok) begin
      err_q     <= (block_size == '0);
      abort_q   <= 1'b0;
      multi_q   <= multi_block;
      auto_q    <= auto_cmd12_en;
      bounded_q <= bounded_in;
      dir_q     <= dir_read;
      len_q     <= block_size;
    end else begin
      if (state == ST_IDLE) begin
        abort_q <= 1'b0;
      end else if (abort) begin
        abort_q <= 1'b1;
      end
      if (state == ST_PHY_WAIT && dat.phy_done && dat.phy_crc_err) begin
        err_q <= 1'b1;
      end
    end
  end

  assign dat.phy_start = (state == ST_LAUNCH);
  assign dat.phy_len   = len_q;
  assign dat.phy_dir   = dir_q;
  assign dat.cmd12_req = (state == ST_STOP_REQ);

  assign busy      = (state != ST_IDLE);
  assign xfer_done = (state == ST_FINISH) & ~err_q;
  assign xfer_err  = (state == ST_FINISH) & err_q;

endmodule

// File: tb/tb_dat_xfer_sched.sv
// Randomized bench for dat_xfer_sched with a transaction-level model.
// Model predicts block count, outcome, CMD12 and final blocks_left.
module tb_dat_xfer_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        sw_reset_dat;
  logic        start;
  logic        multi_block;
  logic        dir_read;
  logic        blk_cnt_en;
  logic        auto_cmd12_en;
  logic [11:0] block_size;
  logic [15:0] block_count;
  logic        abort;
  logic        fifo_ack;
  logic        busy;
  logic        xfer_done;
  logic        xfer_err;
  logic [15:0] blocks_left;

  int n_chk  = 0;
  int n_pass = 0;

  dat_xfer_sched_if #(.BLKSZ_W(12)) dat_if ();

  dat_xfer_sched #(
    .BLKSZ_W  (12),
    .BLKCNT_W (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .sw_reset_dat  (sw_reset_dat),
    .start         (start),
    .multi_block   (multi_block),
    .dir_read      (dir_read),
    .blk_cnt_en    (blk_cnt_en),
    .auto_cmd12_en (auto_cmd12_en),
    .block_size    (block_size),
    .block_count   (block_count),
    .abort         (abort),
    .fifo_ack      (fifo_ack),
    .dat           (dat_if),
    .busy          (busy),
    .xfer_done     (xfer_done),
    .xfer_err      (xfer_err),
    .blocks_left   (blocks_left)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One transfer: predict its outcome, then play FIFO/phy/cmd agent.
  task automatic run_xfer(input bit m, input bit ce, input bit ac,
                          input bit dr, input logic [11:0] sz,
                          input logic [15:0] cnt, input int crc_blk,
                          input int abort_blk, input int hold,
                          output int end_cyc);
    bit bnd;
    int nblk;
    int stop;
    int e_starts;
    int e_left;
    bit e_err;
    bit e_c12;
    int starts;
    int cyc;
    int phy_cd;
    int ack_cd;
    bit ack_pend;
    bit ended;
    bit got_done;
    bit got_err;
    bit both;
    bit c12;

    bnd  = !m || ce;
    nblk = !m ? 1 : (ce ? int'(cnt) : 32'h4000_0000);
    if (sz == 0) begin
      e_starts = 0; e_err = 1; e_c12 = 0; e_left = nblk;
    end else if (nblk == 0) begin
      e_starts = 0; e_err = 0; e_c12 = 0; e_left = 0;
    end else begin
      stop = nblk;
      if (m && abort_blk > 0 && abort_blk < stop) stop = abort_blk;
      if (crc_blk > 0 && crc_blk <= stop) begin
        e_starts = crc_blk; e_err = 1; e_left = nblk - (crc_blk - 1);
      end else begin
        e_starts = stop; e_err = 0; e_left = nblk - stop;
      end
      e_c12 = m && ac;
    end

    starts = 0; cyc = 0; phy_cd = 0; ack_cd = 0; ack_pend = 0;
    ended = 0; got_done = 0; got_err = 0; both = 0; c12 = 0;
    end_cyc = -1;

    @(negedge clk);
    multi_block = m; blk_cnt_en = ce; auto_cmd12_en = ac;
    dir_read = dr; block_size = sz; block_count = cnt;
    start = 1'b1;

    while (!ended && cyc < 4000) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      dat_if.phy_done = 1'b0;
      dat_if.phy_crc_err = 1'b0;
      dat_if.cmd12_ack = 1'b0;
      if (dat_if.phy_start) begin
        starts++;
        check("phy_len", 32'(dat_if.phy_len), 32'(sz));
        check("phy_dir", 32'(dat_if.phy_dir), 32'(dr));
        if (bnd) check("left_at_start", 32'(blocks_left), 32'(nblk - starts + 1));
        phy_cd = 1 + int'($urandom % 8);
        if (starts == abort_blk) abort = 1'b1;
      end else if (phy_cd > 0) begin
        phy_cd--;
        if (phy_cd == 0) begin
          dat_if.phy_done = 1'b1;
          dat_if.phy_crc_err = (starts == crc_blk);
        end
      end
      if (dat_if.cmd12_req) begin
        c12 = 1;
        if (!ack_pend) begin
          ack_pend = 1;
          ack_cd = int'($urandom % 4);
        end
      end
      if (ack_pend) begin
        if (ack_cd == 0) begin
          dat_if.cmd12_ack = 1'b1;
          ack_pend = 0;
        end else begin
          ack_cd--;
        end
      end
      if (hold > 0 && cyc == hold - 1) begin
        check("fifo_wait_busy", 32'(busy), 1);
        check("fifo_wait_nostart", 32'(starts), 0);
      end
      if (xfer_done && xfer_err) both = 1;
      if (xfer_done || xfer_err) begin
        ended = 1;
        got_done = xfer_done;
        got_err = xfer_err;
        end_cyc = cyc;
        check("busy_at_end", 32'(busy), 1);
        if (bnd) check("blocks_left", 32'(blocks_left), 32'(e_left));
      end
      fifo_ack = (cyc >= hold) && ($urandom % 3 != 0);
      cyc++;
    end

    check("xfer_end", 32'(ended), 1);
    check("phy_starts", 32'(starts), 32'(e_starts));
    check("xfer_err", 32'(got_err), 32'(e_err));
    check("xfer_done", 32'(got_done), 32'(!e_err));
    check("done_err_excl", 32'(both), 0);
    check("cmd12_seen", 32'(c12), 32'(e_c12));
    @(negedge clk);
    fifo_ack = 1'b0;
    check("busy_after", 32'(busy), 0);
    check("cmd12_after", 32'(dat_if.cmd12_req), 0);
  endtask

  int ec;
  int n_st;
  int cd;
  int cy;
  bit seen;
  bit m_r;
  bit ce_r;
  int crc_r;
  int ab_r;
  logic [11:0] sz_r;

  initial begin
    reset = 1'b1; sw_reset_dat = 1'b0; start = 1'b0;
    multi_block = 1'b0; dir_read = 1'b0; blk_cnt_en = 1'b0;
    auto_cmd12_en = 1'b0; block_size = '0; block_count = '0;
    abort = 1'b0; fifo_ack = 1'b0;
    dat_if.phy_done = 1'b0; dat_if.phy_crc_err = 1'b0;
    dat_if.cmd12_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_left", 32'(blocks_left), 0);
    check("rst_len", 32'(dat_if.phy_len), 0);
    check("rst_dir", 32'(dat_if.phy_dir), 0);
    check("rst_cmd12", 32'(dat_if.cmd12_req), 0);
    check("rst_pulses", 32'({dat_if.phy_start, xfer_done, xfer_err}), 0);
    reset = 1'b0;

    run_xfer(0, 0, 0, 1, 12'd512, 16'd0, 0, 0, 0, ec);
    run_xfer(1, 1, 1, 0, 12'd512, 16'd3, 0, 0, 0, ec);
    run_xfer(1, 1, 1, 1, 12'd64, 16'd4, 2, 0, 0, ec);
    run_xfer(1, 0, 0, 1, 12'd128, 16'd0, 0, 5, 0, ec);
    run_xfer(1, 1, 0, 0, 12'd256, 16'd0, 0, 0, 0, ec);
    check("cnt0_latency", 32'(ec), 0);
    run_xfer(0, 0, 0, 0, 12'd0, 16'd0, 0, 0, 0, ec);
    run_xfer(0, 0, 0, 0, 12'd2048, 16'd0, 0, 0, 1000, ec);

    // Software reset while block 2 of 8 is on the phy.
    @(negedge clk);
    multi_block = 1'b1; blk_cnt_en = 1'b1; auto_cmd12_en = 1'b1;
    dir_read = 1'b0; block_size = 12'd64; block_count = 16'd8;
    start = 1'b1; fifo_ack = 1'b1;
    n_st = 0; cd = 0; cy = 0;
    while (n_st < 2 && cy < 200) begin
      @(negedge clk);
      start = 1'b0;
      dat_if.phy_done = 1'b0;
      if (dat_if.phy_start) begin
        n_st++;
        cd = 3;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) dat_if.phy_done = 1'b1;
      end
      cy++;
    end
    check("swr_reach", 32'(n_st), 2);
    @(negedge clk);
    check("left_before_swr", 32'(blocks_left), 7);
    sw_reset_dat = 1'b1;
    @(negedge clk);
    sw_reset_dat = 1'b0; fifo_ack = 1'b0;
    check("swr_busy", 32'(busy), 0);
    check("swr_left", 32'(blocks_left), 0);
    check("swr_cmd12", 32'(dat_if.cmd12_req), 0);
    seen = 0;
    if (xfer_done || xfer_err) seen = 1;
    repeat (6) begin
      @(negedge clk);
      if (xfer_done || xfer_err || dat_if.phy_start) seen = 1;
    end
    check("swr_silent", 32'(seen), 0);
    run_xfer(1, 1, 1, 1, 12'd32, 16'd2, 0, 0, 0, ec);

    for (int i = 0; i < 25; i++) begin
      m_r  = 1'($urandom % 2);
      ce_r = 1'($urandom % 2);
      sz_r = ($urandom % 8 == 0) ? 12'd0 : 12'(1 + $urandom % 2048);
      crc_r = ($urandom % 3 == 0) ? int'(1 + $urandom % 6) : 0;
      if (m_r && !ce_r) ab_r = int'(1 + $urandom % 6);
      else ab_r = ($urandom % 3 == 0) ? int'(1 + $urandom % 6) : 0;
      run_xfer(m_r, ce_r, 1'($urandom % 2), 1'($urandom % 2), sz_r,
               16'($urandom % 6), crc_r, ab_r, int'($urandom % 4), ec);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
